// File: rtl/arbitro_multiplicador.sv
// Round-robin arbiter that shares one Booth multiplier among NUM_REQ requesters.
// Grants one requester at a time, waits for the multiplier Fin edge and returns the product.
module arbitro_multiplicador #(
    parameter int unsigned NUM_BITS = 3,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*NUM_BITS-1:0]   op_a,
    input  logic [NUM_REQ*NUM_BITS-1:0]   op_b,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            error,
    output logic [2*NUM_BITS-1:0]         resultado,
    output logic                          ocupado,
    output logic [NUM_BITS-1:0]           m_multiplicando,
    output logic [NUM_BITS-1:0]           m_multiplicador,
    output logic                          m_start,
    input  logic [2*NUM_BITS-1:0]         m_resultado,
    input  logic                          m_fin
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StEspera,
        StEntrega
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic            fin_q;

    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_next;
    logic            fin_rise;

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        int j;
        win_valid = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            j = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (req[j]) begin
                win_valid = 1'b1;
                win_idx   = PW'(j);
            end
        end
    end

    assign ptr_next = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    assign fin_rise = m_fin & ~fin_q;
    assign ocupado  = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            ptr_q           <= '0;
            owner_q         <= '0;
            cnt_q           <= '0;
            fin_q           <= 1'b0;
            gnt             <= '0;
            done            <= '0;
            error           <= '0;
            resultado       <= '0;
            m_multiplicando <= '0;
            m_multiplicador <= '0;
            m_start         <= 1'b0;
        end else begin
            fin_q   <= m_fin;
            gnt     <= '0;
            done    <= '0;
            error   <= '0;
            m_start <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        m_multiplicando <= op_a[win_idx*NUM_BITS +: NUM_BITS];
                        m_multiplicador <= op_b[win_idx*NUM_BITS +: NUM_BITS];
                        gnt[win_idx]    <= 1'b1;
                        m_start         <= 1'b1;
                        owner_q         <= win_idx;
                        ptr_q           <= ptr_next;
                        cnt_q           <= '0;
                        state_q         <= StEspera;
                    end
                end
                StEspera: begin
                    // A Fin edge in the final watchdog cycle still completes the operation.
                    if (fin_rise) begin
                        resultado     <= m_resultado;
                        done[owner_q] <= 1'b1;
                        state_q       <= StEntrega;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        error[owner_q] <= 1'b1;
                        state_q        <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StEntrega: state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_multiplicador.sv
// Bench for arbitro_multiplicador: plays the multiplier role and checks against
// a round-robin reference model with arithmetic products.
module tb_arbitro_multiplicador;

    localparam int NB = 3;
    localparam int NR = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [NR*NB-1:0] op_a, op_b;
    logic [NR-1:0] gnt, done, error;
    logic [2*NB-1:0] resultado;
    logic          ocupado;
    logic [NB-1:0] m_multiplicando, m_multiplicador;
    logic          m_start;
    logic [2*NB-1:0] m_resultado;
    logic          m_fin;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ptr_m    = 0;
    logic [5:0]  last_res = '0;

    always #5 clk = ~clk;

    arbitro_multiplicador #(.NUM_BITS(NB), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done(done), .error(error), .resultado(resultado), .ocupado(ocupado),
        .m_multiplicando(m_multiplicando), .m_multiplicador(m_multiplicador),
        .m_start(m_start), .m_resultado(m_resultado), .m_fin(m_fin)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // First requester at or after p, wrapping.
    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [5:0] prod(input logic [2:0] a, input logic [2:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[5:0];
    endfunction

    // One complete operation; lo = cycles with Fin low before its rising edge,
    // stale = Fin already high at grant and kept high for two cycles first.
    task automatic run_op(input logic [NR-1:0] r, input int lo, input bit stale);
        int w;
        logic [2:0] a, b;
        logic [5:0] p;
        w = pick(r, ptr_m);
        a = op_a[w*NB +: NB];
        b = op_b[w*NB +: NB];
        p = prod(a, b);
        req = r;
        tick();
        chk("gnt", gnt, 1 << w);
        chk("m_start", m_start, 1);
        chk("m_multiplicando", m_multiplicando, a);
        chk("m_multiplicador", m_multiplicador, b);
        chk("ocupado_busy", ocupado, 1);
        ptr_m = (w + 1) % NR;
        req = r & ~NR'(1 << w);
        m_resultado = 6'($urandom);
        if (stale) begin
            repeat (2) begin
                tick();
                chk("stale_no_done", done, 0);
                chk("stale_busy", ocupado, 1);
            end
            m_fin = 1'b0;
        end
        repeat (lo) begin
            tick();
            chk("wait_no_done", done, 0);
            chk("start_pulse", m_start, 0);
        end
        m_resultado = p;
        m_fin = 1'b1;
        tick();
        chk("done", done, 1 << w);
        chk("resultado", resultado, p);
        chk("operand_stable", m_multiplicando, a);
        chk("gnt_quiet", gnt, 0);
        last_res = p;
        req = '0;
        m_resultado = 6'($urandom);
        tick();
        chk("done_pulse", done, 0);
        chk("ocupado_idle", ocupado, 0);
        chk("gnt_gap", gnt, 0);
        chk("resultado_held", resultado, p);
        m_fin = 1'b0;
    endtask

    task automatic run_timeout(input logic [NR-1:0] r);
        int w, k;
        bit saw_done;
        w = pick(r, ptr_m);
        req = r;
        tick();
        chk("to_gnt", gnt, 1 << w);
        ptr_m = (w + 1) % NR;
        req = '0;
        m_fin = 1'b0;
        m_resultado = 6'($urandom);
        k = 0;
        saw_done = 1'b0;
        while (error === '0 && k < 200) begin
            tick();
            k++;
            if (done !== '0) saw_done = 1'b1;
        end
        chk("to_cycles", k, TO);
        chk("to_error", error, 1 << w);
        chk("to_no_done", saw_done, 0);
        chk("to_res_kept", resultado, last_res);
        chk("to_idle", ocupado, 0);
        tick();
        chk("to_error_pulse", error, 0);
    endtask

    initial begin
        logic [NR-1:0] r;
        bit st;
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; m_fin = 1'b0; m_resultado = '0;
        tick();
        tick();
        chk("rst_pulses", {gnt, done, error, m_start, ocupado}, 0);
        chk("rst_outputs", {resultado, m_multiplicando, m_multiplicador}, 0);
        rst = 1'b0;
        tick();

        // Single request: -4 * 3
        op_a[2:0] = 3'b100;
        op_b[2:0] = 3'b011;
        run_op(4'b0001, 3, 1'b0);
        chk("single_minus12", resultado, 6'b110100);

        rst = 1'b1; tick(); rst = 1'b0; ptr_m = 0; last_res = '0; tick();

        // All requesters held
        op_a = {3'd3, 3'b101, 3'd2, 3'd1};
        op_b = {3'd2, 3'b101, 3'b111, 3'd1};
        for (int i = 0; i < NR; i++) run_op(4'b1111, i, 1'b0);

        // Pointer rotation
        run_op(4'b0100, 1, 1'b0);
        run_op(4'b0101, 0, 1'b0);
        run_op(4'b0101, 2, 1'b0);

        run_timeout(4'b0010);

        // Fin held high through idle, then stale at grant
        m_fin = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_fin_no_done", done, 0);
            chk("idle_fin_idle", ocupado, 0);
        end
        op_a = 12'($urandom);
        op_b = 12'($urandom);
        run_op(4'b1000, 1, 1'b1);

        // Randomized traffic
        repeat (24) begin
            op_a = 12'($urandom);
            op_b = 12'($urandom);
            r = NR'($urandom_range(1, 15));
            st = 1'($urandom_range(0, 1));
            if (st) m_fin = 1'b1;
            run_op(r, st ? 1 + $urandom_range(0, 3) : $urandom_range(0, 4), st);
        end

        // Reset in the middle of ESPERA
        op_a = 12'($urandom);
        op_b = 12'($urandom);
        req = 4'b0110;
        tick();
        chk("mid_gnt", gnt, 1 << pick(4'b0110, ptr_m));
        req = '0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_pulses", {gnt, done, error, m_start, ocupado}, 0);
        chk("mid_rst_outputs", {resultado, m_multiplicando, m_multiplicador}, 0);
        tick();
        rst = 1'b0;
        ptr_m = 0;
        last_res = '0;
        tick();
        chk("mid_no_done", done, 0);
        run_op(4'b1000, 2, 1'b0);
        run_op(4'b1111, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
